// File: rtl/pipelined_block_adder.sv
// pipelined_block_adder
//   Pipelined block-carry adder computing a + b + cin over WIDTH bits.
//   Operands are cut into BLK-bit lookahead blocks. STAGE_BLKS blocks are
//   resolved per pipeline stage, and the carry between stages is registered.
//   Unresolved operand bits and already-resolved sum bits travel with each
//   beat, so a result leaves the pipe NSTG edges after it was accepted.
//   The stream interface is valid/ready. The whole pipe advances as a unit
//   whenever the output slot is empty or is being consumed.
//   Optional feature: define ACLA_APPROX_EN to cut the carry chain at block
//   boundaries and raise err when that approximation changes the result.
module pipelined_block_adder #(
    parameter int WIDTH      = 32,
    parameter int BLK        = 4,
    parameter int STAGE_BLKS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err
);

    localparam int NBLK = WIDTH / BLK;
    localparam int NSTG = (NBLK + STAGE_BLKS - 1) / STAGE_BLKS;

    // One pipeline slot: the operands, the partial sum, and the carry state
    // that the next stage needs. apxCarry and err are only meaningful when
    // the carry chain is approximated.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] opA;
        logic [WIDTH-1:0] opB;
        logic [WIDTH-1:0] sumBits;
        logic             carry;
        logic             apxCarry;
        logic             err;
    } stage_t;

    // Adds one block with lookahead carries from carry-in c.
    // The result is packed as {group generate, group propagate, sum bits}.
    // The group generate is computed with a carry-in of 0, so it does not
    // depend on c.
    function automatic logic [BLK+1:0] blockAdd(input logic [BLK-1:0] x,
                                                input logic [BLK-1:0] y,
                                                input logic           c);
        logic [BLK-1:0] g;
        logic [BLK-1:0] p;
        logic [BLK:0]   cy;
        logic           bg;
        logic           bp;
        g     = x & y;
        p     = x ^ y;
        cy    = '0;
        cy[0] = c;
        bg    = 1'b0;
        bp    = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            cy[i+1] = g[i] | (p[i] & cy[i]);
            bg      = g[i] | (p[i] & bg);
            bp      = bp & p[i];
        end
        return {bg, bp, p ^ cy[BLK-1:0]};
    endfunction

    logic advance;

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        localparam int FIRST = s * STAGE_BLKS;
        localparam int LAST  = ((s + 1) * STAGE_BLKS < NBLK) ? (s + 1) * STAGE_BLKS : NBLK;

        stage_t         srcW;
        stage_t         stageD;
        stage_t         stageQ;
        logic           trueC;
        logic [BLK+1:0] res;
`ifdef ACLA_APPROX_EN
        logic           apxC;
        logic           errAcc;
`endif

        if (s == 0) begin : g_src
            assign srcW = '{valid: in_valid, opA: a, opB: b, sumBits: '0,
                            carry: cin, apxCarry: cin, err: 1'b0};
        end else begin : g_src
            assign srcW = g_stage[s-1].stageQ;
        end

        // Resolve this stage's blocks and pass the carry state on to the next stage.
        always_comb begin
            stageD = srcW;
            trueC  = srcW.carry;
            res    = '0;
`ifdef ACLA_APPROX_EN
            apxC   = srcW.apxCarry;
            errAcc = srcW.err;
`endif
            for (int k = FIRST; k < LAST; k++) begin
`ifdef ACLA_APPROX_EN
                res    = blockAdd(srcW.opA[k*BLK +: BLK], srcW.opB[k*BLK +: BLK], apxC);
                errAcc = errAcc | (res[BLK] & trueC);
                apxC   = res[BLK+1];
`else
                res    = blockAdd(srcW.opA[k*BLK +: BLK], srcW.opB[k*BLK +: BLK], trueC);
`endif
                stageD.sumBits[k*BLK +: BLK] = res[BLK-1:0];
                trueC = res[BLK+1] | (res[BLK] & trueC);
            end
            stageD.carry = trueC;
`ifdef ACLA_APPROX_EN
            stageD.apxCarry = apxC;
            stageD.err      = errAcc;
`endif
        end

        // Stage register: it shifts only when the whole pipe advances, and reset drops any beat in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stageQ <= '0;
            end else if (advance) begin
                stageQ <= stageD;
            end
        end
    end

    // The pipe moves when the output slot is empty or is being drained.
    always_comb begin
        advance = !g_stage[NSTG-1].stageQ.valid || out_ready;
    end

    assign in_ready  = advance;
    assign out_valid = g_stage[NSTG-1].stageQ.valid;
`ifdef ACLA_APPROX_EN
    assign sum = {g_stage[NSTG-1].stageQ.apxCarry, g_stage[NSTG-1].stageQ.sumBits};
    assign err = g_stage[NSTG-1].stageQ.err;
`else
    assign sum = {g_stage[NSTG-1].stageQ.carry, g_stage[NSTG-1].stageQ.sumBits};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_block_adder.sv
// Testbench for pipelined_block_adder: default 32/4/2 build plus 16/4/4 and 64/8/1 variants.
module tb_pipelined_block_adder;

    localparam int NSTG32 = 4;
    localparam int NSTG16 = 1;
    localparam int NSTG64 = 8;

    typedef struct {
        logic [64:0] sum;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    logic        inValid, inReady, cin, outValid, outReady, err;
    logic [31:0] a, b;
    logic [32:0] sum;

    logic        inValid16, inReady16, cin16, outValid16, outReady16, err16;
    logic [15:0] a16, b16;
    logic [16:0] sum16;

    logic        inValid64, inReady64, cin64, outValid64, outReady64, err64;
    logic [63:0] a64, b64;
    logic [64:0] sum64;

    exp_t q32[$];
    exp_t q16[$];
    exp_t q64[$];

    // The clock and a cycle counter used to measure latency.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_block_adder #(.WIDTH(32), .BLK(4), .STAGE_BLKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .a(a), .b(b), .cin(cin), .out_valid(outValid), .out_ready(outReady),
        .sum(sum), .err(err));

    pipelined_block_adder #(.WIDTH(16), .BLK(4), .STAGE_BLKS(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(outValid16), .out_ready(outReady16),
        .sum(sum16), .err(err16));

    pipelined_block_adder #(.WIDTH(64), .BLK(8), .STAGE_BLKS(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid64), .in_ready(inReady64),
        .a(a64), .b(b64), .cin(cin64), .out_valid(outValid64), .out_ready(outReady64),
        .sum(sum64), .err(err64));

    // Reference model. Exact mode adds at full width. Approximate mode adds
    // each block on its own, taking the carry out of the previous block
    // summed with a carry-in of 0.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic c, input int w, input int blk);
        exp_t        e;
        logic [64:0] exact, approx, mask, xa, ya, xp, yp, cc;
        exact  = {1'b0, x} + {1'b0, y} + {64'd0, c};
        mask   = (65'd1 << blk) - 65'd1;
        approx = '0;
        xp     = '0;
        yp     = '0;
        for (int k = 0; k < w / blk; k++) begin
            xa = ({1'b0, x} >> (k * blk)) & mask;
            ya = ({1'b0, y} >> (k * blk)) & mask;
            cc = (k == 0) ? {64'd0, c} : (((xp + yp) >> blk) & 65'd1);
            approx = approx | (((xa + ya + cc) & mask) << (k * blk));
            xp = xa;
            yp = ya;
        end
        approx = approx | ((((xp + yp) >> blk) & 65'd1) << w);
`ifdef ACLA_APPROX_EN
        e.sum = approx;
        e.err = (approx != exact);
`else
        e.sum = exact;
        e.err = 1'b0;
`endif
        e.cyc = 0;
        return e;
    endfunction

    // Pushes the expected result when the main DUT accepts a beat this cycle.
    task automatic applyStimulus32();
        exp_t e;
        if (inValid && inReady) begin
            e     = model({32'd0, a}, {32'd0, b}, cin, 32, 4);
            e.cyc = cyc;
            q32.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0; a = '0; b = '0; cin = 1'b0;
        inValid16 = 1'b0; outReady16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        inValid64 = 1'b0; outReady64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
        #2;
        compared++;
        if (outValid !== 1'b0 || sum !== 33'd0 || err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: out_valid=%b sum=%h err=%b, required 0/0/0", outValid, sum, err);
        end
        compared++;
        if (inReady !== 1'b1 || outValid16 !== 1'b0 || outValid64 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready: in_ready=%b ov16=%b ov64=%b, required 1/0/0", inReady, outValid16, outValid64);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        int   seen = 0;
        inValid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; outReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            applyStimulus32();
            if (outValid && outReady) begin
                compared++;
                seen++;
                if (q32.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL single_extra: unexpected sum=%h", sum);
                end else begin
                    e = q32.pop_front();
                    if (sum !== e.sum[32:0] || err !== e.err || cyc - e.cyc != NSTG32) begin
                        mismatched++;
                        $display("[TB] FAIL single: sum=%h err=%b lat=%0d, required %h/%b/%0d",
                                 sum, err, cyc - e.cyc, e.sum[32:0], e.err, NSTG32);
                    end
                end
            end
            @(negedge clk);
            inValid = 1'b0;
        end
        compared++;
        if (seen != 1 || q32.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL single_count: results=%0d pending=%0d, required 1/0", seen, q32.size());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seen = 0;
        int   prevCyc = -1;
        outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            inValid = (i < 8);
            a = i; b = 10 * i; cin = 1'(i);
            #1;
            applyStimulus32();
            if (outValid && outReady) begin
                compared++;
                if (q32.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_extra: unexpected sum=%h", sum);
                end else begin
                    e = q32.pop_front();
                    if (sum !== e.sum[32:0] || err !== e.err || cyc - e.cyc != NSTG32 ||
                        (prevCyc >= 0 && cyc != prevCyc + 1)) begin
                        mismatched++;
                        $display("[TB] FAIL b2b_%0d: sum=%h err=%b lat=%0d gap=%0d, required %h/%b/%0d/1",
                                 seen, sum, err, cyc - e.cyc, cyc - prevCyc, e.sum[32:0], e.err, NSTG32);
                    end
                end
                prevCyc = cyc;
                seen++;
            end
            @(negedge clk);
        end
        compared++;
        if (seen != 8 || q32.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: results=%0d pending=%0d, required 8/0", seen, q32.size());
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            inValid  = (i < 9);
            outReady = !(i >= 6 && i < 9);
            a = $urandom; b = $urandom; cin = 1'($urandom);
            #1;
            if (!outReady) begin
                compared++;
                if (inReady !== 1'b0 || outValid !== 1'b1 || q32.size() == 0 || sum !== q32[0].sum[32:0]) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: in_ready=%b out_valid=%b sum=%h, required 0/1/%h",
                             inReady, outValid, sum, (q32.size() != 0) ? q32[0].sum[32:0] : 33'd0);
                end
            end
            applyStimulus32();
            if (outValid && outReady) begin
                compared++;
                if (q32.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_extra: unexpected sum=%h", sum);
                end else begin
                    e = q32.pop_front();
                    if (sum !== e.sum[32:0] || err !== e.err) begin
                        mismatched++;
                        $display("[TB] FAIL stall_data: sum=%h err=%b, required %h/%b", sum, err, e.sum[32:0], e.err);
                    end
                end
            end
            @(negedge clk);
        end
        compared++;
        if (q32.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_lost: pending=%0d, required 0", q32.size());
        end
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        int   seen = 0;
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1;
            #1;
            applyStimulus32();
            @(negedge clk);
        end
        inValid = 1'b0;
        rst_n = 1'b0;
        #1;
        compared++;
        if (outValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flush: out_valid=%b, required 0", outValid);
        end
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inValid = (i == 8);
            a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1;
            #1;
            applyStimulus32();
            if (outValid && outReady) begin
                compared++;
                seen++;
                if (q32.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL reset_stale: unexpected sum=%h", sum);
                end else begin
                    e = q32.pop_front();
                    if (sum !== e.sum[32:0] || err !== e.err || cyc - e.cyc != NSTG32) begin
                        mismatched++;
                        $display("[TB] FAIL reset_new: sum=%h err=%b lat=%0d, required %h/%b/%0d",
                                 sum, err, cyc - e.cyc, e.sum[32:0], e.err, NSTG32);
                    end
                end
            end
            @(negedge clk);
        end
        compared++;
        if (seen != 1 || q32.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: results=%0d pending=%0d, required 1/0", seen, q32.size());
        end
    endtask

`ifdef ACLA_APPROX_EN
    task automatic test_approx();
        logic [32:0] wantSum [2];
        logic        wantErr [2];
        int          seen = 0;
        wantSum[0] = 33'h0_0000_0000; wantErr[0] = 1'b1;
        wantSum[1] = 33'h0_0000_0010; wantErr[1] = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 12; i++) begin
            inValid = (i < 2);
            a = (i == 0) ? 32'h0000_00FF : 32'h0000_000F;
            b = 32'h0000_0001; cin = 1'b0;
            #1;
            if (outValid && outReady) begin
                compared++;
                if (seen > 1 || sum !== wantSum[seen] || err !== wantErr[seen]) begin
                    mismatched++;
                    $display("[TB] FAIL approx_%0d: sum=%h err=%b, required %h/%b",
                             seen, sum, err, wantSum[seen & 1], wantErr[seen & 1]);
                end
                seen++;
            end
            @(negedge clk);
        end
        compared++;
        if (seen != 2) begin
            mismatched++;
            $display("[TB] FAIL approx_count: results=%0d, required 2", seen);
        end
    endtask
`endif

    task automatic test_param_variants();
        exp_t e;
        int   acc16 = 0;
        int   acc64 = 0;
        bit   done = 0;
        for (int n = 0; n < 20000 && !done; n++) begin
            inValid16  = (acc16 < 1000) && ($urandom_range(0, 3) != 0);
            outReady16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            inValid64  = (acc64 < 1000) && ($urandom_range(0, 3) != 0);
            outReady64 = ($urandom_range(0, 3) != 0);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; cin64 = 1'($urandom);
            #1;
            if (inValid16 && inReady16) begin
                e = model({48'd0, a16}, {48'd0, b16}, cin16, 16, 4);
                e.cyc = cyc;
                q16.push_back(e);
                acc16++;
            end
            if (inValid64 && inReady64) begin
                e = model(a64, b64, cin64, 64, 8);
                e.cyc = cyc;
                q64.push_back(e);
                acc64++;
            end
            if (outValid16 && outReady16) begin
                compared++;
                if (q16.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL w16_extra: unexpected sum=%h", sum16);
                end else begin
                    e = q16.pop_front();
                    if (sum16 !== e.sum[16:0] || err16 !== e.err || cyc - e.cyc < NSTG16) begin
                        mismatched++;
                        $display("[TB] FAIL w16: sum=%h err=%b lat=%0d, required %h/%b/>=%0d",
                                 sum16, err16, cyc - e.cyc, e.sum[16:0], e.err, NSTG16);
                    end
                end
            end
            if (outValid64 && outReady64) begin
                compared++;
                if (q64.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL w64_extra: unexpected sum=%h", sum64);
                end else begin
                    e = q64.pop_front();
                    if (sum64 !== e.sum || err64 !== e.err || cyc - e.cyc < NSTG64) begin
                        mismatched++;
                        $display("[TB] FAIL w64: sum=%h err=%b lat=%0d, required %h/%b/>=%0d",
                                 sum64, err64, cyc - e.cyc, e.sum, e.err, NSTG64);
                    end
                end
            end
            done = (acc16 == 1000) && (acc64 == 1000) && (q16.size() == 0) && (q64.size() == 0);
            @(negedge clk);
        end
        inValid16 = 1'b0; inValid64 = 1'b0;
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL variants_timeout: acc16=%0d acc64=%0d pending16=%0d pending64=%0d, required 1000/1000/0/0",
                     acc16, acc64, q16.size(), q64.size());
        end
    endtask

    // Runs each scenario in order, then prints the summary line.
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
`ifdef ACLA_APPROX_EN
        test_approx();
`endif
        test_param_variants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
